// File: rtl/mem_cycle_arbiter.sv
// Two-port arbiter in front of the SRAM read/write cycle sequencer.
// Holds read/write for (len+1)*CYC_LEN clocks, steps the address per beat, pulses done.
module mem_cycle_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int LEN_W   = 4,
  parameter int CYC_LEN = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              beat_end,
  output logic              busy
);

  localparam int CYC_W = (CYC_LEN > 1) ? $clog2(CYC_LEN) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [CYC_W-1:0]   cyc, cyc_nx;
  logic [LEN_W-1:0]   beat, beat_nx, len, len_nx;
  logic               we, we_nx;
  logic               last, last_nx;   // last granted requester; also the current owner
  logic [1:0]         grant_nx, done_nx;
  logic               read_nx, write_nx, beat_end_nx, busy_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic               win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cyc      <= '0;
      beat     <= '0;
      len      <= '0;
      we       <= 1'b0;
      last     <= 1'b1;   // so requester 0 wins the first tie
      grant    <= '0;
      done     <= '0;
      read     <= 1'b0;
      write    <= 1'b0;
      mem_addr <= '0;
      beat_end <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cyc      <= cyc_nx;
      beat     <= beat_nx;
      len      <= len_nx;
      we       <= we_nx;
      last     <= last_nx;
      grant    <= grant_nx;
      done     <= done_nx;
      read     <= read_nx;
      write    <= write_nx;
      mem_addr <= addr_nx;
      beat_end <= beat_end_nx;
      busy     <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cyc_nx      = cyc;
    beat_nx     = beat;
    len_nx      = len;
    we_nx       = we;
    last_nx     = last;
    grant_nx    = grant;
    done_nx     = '0;
    read_nx     = read;
    write_nx    = write;
    addr_nx     = mem_addr;
    beat_end_nx = 1'b0;
    busy_nx     = busy;
    win         = (req == 2'b11) ? ~last : req[1];

    case (state)
      IDLE: begin
        grant_nx = '0;
        read_nx  = 1'b0;
        write_nx = 1'b0;
        addr_nx  = '0;
        busy_nx  = 1'b0;
        if (req != 2'b00) begin
          state_nx = RUN;
          last_nx  = win;
          grant_nx = win ? 2'b10 : 2'b01;
          busy_nx  = 1'b1;
          addr_nx  = win ? req_addr1 : req_addr0;
          len_nx   = win ? req_len1 : req_len0;
          we_nx    = req_we[win];
          read_nx  = ~req_we[win];
          write_nx = req_we[win];
          cyc_nx   = '0;
          beat_nx  = '0;
        end
      end
      RUN: begin
        if (cyc == CYC_LAST) begin
          cyc_nx  = '0;
          beat_nx = beat + 1'b1;
          addr_nx = mem_addr + 1'b1;
          if (beat == len) begin
            state_nx = DONE;
            read_nx  = 1'b0;
            write_nx = 1'b0;
            grant_nx = '0;
            done_nx  = last ? 2'b10 : 2'b01;
          end
        end else begin
          cyc_nx      = cyc + 1'b1;
          // registered beat_end lands in the clock where cyc reaches its last value
          beat_end_nx = (cyc_nx == CYC_LAST);
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        addr_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
